// File: rtl/fetch_ctrl_pkg.sv
// Shared definitions for the instruction-fetch sequencer: FSM states,
// the canonical NOP encoding and the default reset fetch address.
package fetch_ctrl_pkg;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2,
    S_HALT = 2'd3
  } fetch_state_e;

  localparam logic [31:0] NOP_INSTR          = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_ADDR = 32'h0000_0000;

endpackage

// File: rtl/fetch_ctrl_pc_next_sel.sv
// Redirect source selection for the fetch PC: priority mux over JAL/JALR/branch,
// target arithmetic and the word-alignment check on the chosen target.
module pc_next_sel (
  input  logic        jmp_en_i,
  input  logic        jmpr_en_i,
  input  logic        jmpb_en_i,
  input  logic [31:0] ex_pc_i,
  input  logic [31:0] jmp_to_i,
  output logic        redirect_o,
  output logic [31:0] target_o,
  output logic        misalign_o
);

  // JAL and branch share the PC-relative adder; JALR only applies when JAL is absent.
  always_comb begin
    target_o = ex_pc_i + jmp_to_i;
    if (!jmp_en_i && jmpr_en_i) begin
      target_o = {jmp_to_i[31:1], 1'b0};
    end
    redirect_o = jmp_en_i | jmpr_en_i | jmpb_en_i;
    misalign_o = redirect_o && (target_o[1:0] != 2'b00);
  end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: drives the imem req/ack handshake, applies
// execute-stage redirects and holds the fetched word while decode stalls.
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_ADDR = DEFAULT_RESET_ADDR,
  parameter int          MAX_WAIT   = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        jmp_en,
  input  logic        jmpr_en,
  input  logic        jmpb_en,
  input  logic [31:0] ex_pc,
  input  logic [31:0] jmp_to,
  input  logic        stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr,
  output logic        misalign,
  output logic        imem_err
);

  localparam int CW = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  tgt_q, tgt_d;
  logic         kill_q, kill_d;
  logic [CW-1:0] wait_cnt_q, wait_cnt_d;
  logic         if_valid_q, if_valid_d;
  logic [31:0]  if_pc_q, if_pc_d;
  logic [31:0]  if_instr_q, if_instr_d;
  logic         misalign_q, misalign_d;
  logic         imem_err_q, imem_err_d;

  logic         redirect;
  logic [31:0]  target;
  logic         misalign_c;

  pc_next_sel u_pc_next_sel (
    .jmp_en_i   (jmp_en),
    .jmpr_en_i  (jmpr_en),
    .jmpb_en_i  (jmpb_en),
    .ex_pc_i    (ex_pc),
    .jmp_to_i   (jmp_to),
    .redirect_o (redirect),
    .target_o   (target),
    .misalign_o (misalign_c)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_REQ;
      pc_q       <= RESET_ADDR;
      tgt_q      <= RESET_ADDR;
      kill_q     <= 1'b0;
      wait_cnt_q <= '0;
      if_valid_q <= 1'b0;
      if_pc_q    <= 32'h0;
      if_instr_q <= 32'h0;
      misalign_q <= 1'b0;
      imem_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      tgt_q      <= tgt_d;
      kill_q     <= kill_d;
      wait_cnt_q <= wait_cnt_d;
      if_valid_q <= if_valid_d;
      if_pc_q    <= if_pc_d;
      if_instr_q <= if_instr_d;
      misalign_q <= misalign_d;
      imem_err_q <= imem_err_d;
    end
  end

  // A misaligned redirect halts fetch from any live state before normal sequencing.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    tgt_d      = tgt_q;
    kill_d     = kill_q;
    wait_cnt_d = wait_cnt_q;
    if_valid_d = if_valid_q;
    if_pc_d    = if_pc_q;
    if_instr_d = if_instr_q;
    misalign_d = 1'b0;
    imem_err_d = imem_err_q;
    if (state_q != S_HALT && misalign_c) begin
      misalign_d = 1'b1;
      if_valid_d = 1'b0;
      state_d    = S_HALT;
    end else begin
      case (state_q)
        S_REQ: begin
          state_d    = S_WAIT;
          wait_cnt_d = '0;
          if_valid_d = 1'b0;
          if (redirect) begin
            kill_d = 1'b1;
            tgt_d  = target;
          end
        end
        S_WAIT: begin
          wait_cnt_d = wait_cnt_q + CW'(1);
          if (imem_ack) begin
            kill_d = 1'b0;
            if (kill_q || redirect) begin
              if_valid_d = 1'b0;
              pc_d       = redirect ? target : tgt_q;
              state_d    = S_REQ;
            end else begin
              if_instr_d = imem_rdata;
              if_pc_d    = pc_q;
              if_valid_d = 1'b1;
              pc_d       = pc_q + 32'd4;
              state_d    = stall ? S_HOLD : S_REQ;
            end
          end else if (wait_cnt_q == CW'(MAX_WAIT - 1)) begin
            imem_err_d = 1'b1;
            if_valid_d = 1'b0;
            state_d    = S_HALT;
          end else begin
            if_valid_d = 1'b0;
            if (redirect) begin
              kill_d = 1'b1;
              tgt_d  = target;
            end
          end
        end
        S_HOLD: begin
          if (redirect) begin
            if_valid_d = 1'b0;
            pc_d       = target;
            state_d    = S_REQ;
          end else if (!stall) begin
            if_valid_d = 1'b0;
            state_d    = S_REQ;
          end
        end
        S_HALT: begin
          if_valid_d = 1'b0;
        end
        default: begin
          state_d = S_REQ;
        end
      endcase
    end
  end

  // Request is masked while reset is asserted so imem never sees a stray fetch.
  always_comb begin
    imem_req = rst_n && (state_q == S_REQ || state_q == S_WAIT);
  end

  assign imem_addr = pc_q;
  assign if_valid  = if_valid_q;
  assign if_pc     = if_pc_q;
  assign if_instr  = if_instr_q;
  assign misalign  = misalign_q;
  assign imem_err  = imem_err_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl with a transaction-level reference model
// compared every cycle, plus literal expectations for the key scenarios.
module tb_fetch_ctrl;

  localparam int          MAX_WAIT   = 16;
  localparam logic [31:0] RESET_ADDR = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        jmp_en, jmpr_en, jmpb_en;
  logic [31:0] ex_pc, jmp_to;
  logic        stall;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic [31:0] if_pc, if_instr;
  logic        misalign, imem_err;

  int total = 0;
  int bad = 0;
  int dataSeq = 0;
  bit started = 1'b0;

  // Reference model: outstanding-fetch bookkeeping rather than a state encoding.
  logic [31:0] mPc = RESET_ADDR, mPend = RESET_ADDR, mIpc = 32'h0, mInstr = 32'h0;
  bit mIssued = 1'b0, mHolding = 1'b0, mHalted = 1'b0, mKill = 1'b0;
  bit mValid = 1'b0, mMis = 1'b0, mErr = 1'b0;
  int mWaited = 0;

  always #5 clk = ~clk;

  fetch_ctrl #(.RESET_ADDR(RESET_ADDR), .MAX_WAIT(MAX_WAIT)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .jmp_en     (jmp_en),
    .jmpr_en    (jmpr_en),
    .jmpb_en    (jmpb_en),
    .ex_pc      (ex_pc),
    .jmp_to     (jmp_to),
    .stall      (stall),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .if_valid   (if_valid),
    .if_pc      (if_pc),
    .if_instr   (if_instr),
    .misalign   (misalign),
    .imem_err   (imem_err)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] redirectTarget(input logic j, input logic jr,
                                                  input logic [31:0] pc, input logic [31:0] to);
    if (j) return pc + to;
    if (jr) return {to[31:1], 1'b0};
    return pc + to;
  endfunction

  task automatic modelStep();
    logic redir;
    logic [31:0] t;
    redir = jmp_en | jmpr_en | jmpb_en;
    t = redirectTarget(jmp_en, jmpr_en, ex_pc, jmp_to);
    started = 1'b1;
    if (!rst_n) begin
      mPc = RESET_ADDR; mPend = RESET_ADDR; mIpc = 32'h0; mInstr = 32'h0;
      mIssued = 0; mHolding = 0; mHalted = 0; mKill = 0;
      mValid = 0; mMis = 0; mErr = 0; mWaited = 0;
    end else begin
      mMis = 0;
      if (mHalted) begin
        mValid = 0;
      end else if (redir && t[1:0] != 2'b00) begin
        mMis = 1; mValid = 0; mHalted = 1; mHolding = 0;
      end else if (mHolding) begin
        if (redir) begin
          mValid = 0; mPc = t; mHolding = 0;
        end else if (!stall) begin
          mValid = 0; mHolding = 0;
        end
      end else if (!mIssued) begin
        mIssued = 1; mWaited = 0; mValid = 0;
        if (redir) begin mKill = 1; mPend = t; end
      end else if (imem_ack) begin
        mIssued = 0;
        if (mKill || redir) begin
          mValid = 0;
          mPc = redir ? t : mPend;
        end else begin
          mInstr = imem_rdata; mIpc = mPc; mValid = 1;
          mPc = mPc + 32'd4; mHolding = stall;
        end
        mKill = 0;
      end else begin
        mWaited++;
        mValid = 0;
        if (mWaited == MAX_WAIT) begin
          mErr = 1; mHalted = 1;
        end else if (redir) begin
          mKill = 1; mPend = t;
        end
      end
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      modelStep();
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (started) begin
        checkOutput("cyc imem_req", 32'(imem_req), 32'(rst_n && !mHalted && !mHolding));
        checkOutput("cyc imem_addr", imem_addr, mPc);
        checkOutput("cyc if_valid", 32'(if_valid), 32'(mValid));
        checkOutput("cyc if_pc", if_pc, mIpc);
        checkOutput("cyc if_instr", if_instr, mInstr);
        checkOutput("cyc misalign", 32'(misalign), 32'(mMis));
        checkOutput("cyc imem_err", 32'(imem_err), 32'(mErr));
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #2;
    jmp_en = 0; jmpr_en = 0; jmpb_en = 0; imem_ack = 0;
  endtask

  task automatic applyStimulus(input logic j, input logic jr, input logic jb,
                               input logic [31:0] pc, input logic [31:0] to, input logic ack);
    jmp_en = j; jmpr_en = jr; jmpb_en = jb; ex_pc = pc; jmp_to = to;
    if (ack) begin
      imem_ack = 1'b1;
      imem_rdata = 32'hBEEF_0000 | 32'(dataSeq);
      dataSeq++;
    end
  endtask

  task automatic fetchOne(input logic stallAtAck);
    tick();
    applyStimulus(0, 0, 0, 32'h0, 32'h0, 1);
    stall = stallAtAck;
    tick();
  endtask

  initial begin
    rst_n = 0; jmp_en = 0; jmpr_en = 0; jmpb_en = 0;
    ex_pc = 32'h0; jmp_to = 32'h0; stall = 0; imem_ack = 0; imem_rdata = 32'h0;
    tick(); tick();
    checkOutput("reset req", 32'(imem_req), 32'd0);
    checkOutput("reset valid", 32'(if_valid), 32'd0);
    checkOutput("reset err", 32'(imem_err), 32'd0);
    rst_n = 1; #1;
    checkOutput("t1 addr0", imem_addr, 32'h0);
    checkOutput("t1 req", 32'(imem_req), 32'd1);

    fetchOne(0);
    checkOutput("t1 addr4", imem_addr, 32'h4);
    checkOutput("t1 if_pc0", if_pc, 32'h0);
    checkOutput("t1 instr0", if_instr, 32'hBEEF_0000);
    checkOutput("t1 valid", 32'(if_valid), 32'd1);
    tick();
    checkOutput("t1 valid gap", 32'(if_valid), 32'd0);
    applyStimulus(0, 0, 0, 32'h0, 32'h0, 1);
    tick();
    checkOutput("t1 addr8", imem_addr, 32'h8);
    checkOutput("t1 if_pc4", if_pc, 32'h4);

    fetchOne(1);
    checkOutput("t4 hold if_pc", if_pc, 32'h8);
    checkOutput("t4 hold valid", 32'(if_valid), 32'd1);
    checkOutput("t4 hold req", 32'(imem_req), 32'd0);
    repeat (4) begin
      tick();
      checkOutput("t4 held req", 32'(imem_req), 32'd0);
      checkOutput("t4 held if_pc", if_pc, 32'h8);
    end
    stall = 0;
    tick();
    checkOutput("t4 release addr", imem_addr, 32'hC);
    checkOutput("t4 release req", 32'(imem_req), 32'd1);

    tick();
    applyStimulus(1, 1, 0, 32'h10, 32'h20, 1);
    tick();
    checkOutput("t2 jmp priority addr", imem_addr, 32'h30);
    checkOutput("t2 flush valid", 32'(if_valid), 32'd0);

    tick();
    applyStimulus(0, 1, 0, 32'h0, 32'h101, 0);
    tick();
    checkOutput("t3 addr held", imem_addr, 32'h30);
    tick(); tick();
    applyStimulus(0, 0, 0, 32'h0, 32'h0, 1);
    tick();
    checkOutput("t3 jalr addr", imem_addr, 32'h100);
    checkOutput("t3 dropped valid", 32'(if_valid), 32'd0);
    fetchOne(0);
    checkOutput("t3 if_pc100", if_pc, 32'h100);
    checkOutput("t3 instr", if_instr, 32'hBEEF_0005);

    tick();
    applyStimulus(1, 0, 0, 32'hFFFF_FFF0, 32'h20, 1);
    tick();
    checkOutput("wrap addr", imem_addr, 32'h10);

    tick();
    applyStimulus(0, 0, 1, 32'h10, 32'h0E, 0);
    tick();
    checkOutput("t5 misalign pulse", 32'(misalign), 32'd1);
    checkOutput("t5 halt req", 32'(imem_req), 32'd0);
    tick();
    checkOutput("t5 misalign clear", 32'(misalign), 32'd0);
    checkOutput("t5 still halted", 32'(imem_req), 32'd0);

    rst_n = 0;
    tick();
    rst_n = 1; #1;
    checkOutput("t6 restart addr", imem_addr, 32'h0);
    repeat (16) tick();
    checkOutput("t6 err before limit", 32'(imem_err), 32'd0);
    tick();
    checkOutput("t6 err raised", 32'(imem_err), 32'd1);
    checkOutput("t6 halt req", 32'(imem_req), 32'd0);
    repeat (3) tick();
    checkOutput("t6 err sticky", 32'(imem_err), 32'd1);
    rst_n = 0;
    tick();
    checkOutput("t6 err cleared", 32'(imem_err), 32'd0);
    rst_n = 1; #1;
    checkOutput("t6 refetch addr", imem_addr, 32'h0);
    checkOutput("t6 refetch req", 32'(imem_req), 32'd1);

    tick();
    rst_n = 0;
    tick();
    rst_n = 1;
    applyStimulus(0, 0, 0, 32'h0, 32'h0, 1);
    tick();
    checkOutput("late ack ignored", 32'(if_valid), 32'd0);
    applyStimulus(0, 0, 0, 32'h0, 32'h0, 1);
    tick();
    checkOutput("post-reset fetch valid", 32'(if_valid), 32'd1);
    checkOutput("post-reset fetch pc", if_pc, 32'h0);
    checkOutput("post-reset next addr", imem_addr, 32'h4);

    tick(); tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
